// File: rtl/data_memory.sv
// Word-organised main memory behind the write-back cache: one line fill or write-back
// at a time, each completing a fixed LATENCY cycles after acceptance with a one-cycle done pulse.
module data_memory #(
   parameter int SIZE      = 65536,
   parameter int LATENCY   = 4,
   parameter int ADDR_BITS = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mem_req,
   input  logic [31:0]     address,
   input  logic            write_en,
   input  logic [0:3][7:0] mem_data_in,
   output logic [0:3][7:0] mem_data_out,
   output logic            mem_busy,
   output logic            mem_done,
   output logic            req_dropped
);
   localparam int WORDS = SIZE / 4;
   localparam int CW    = $clog2(LATENCY) + 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t               state, state_nx;
   logic [CW-1:0]        cnt, cnt_nx;
   logic                 accept, complete;
   logic [ADDR_BITS-3:0] idx;
   logic                 wr;
   logic [31:0]          wdata;
   logic [31:0]          mem [WORDS];
   logic                 unused_addr;

   // Byte offset and bits above the array size do not select a word.
   assign unused_addr = ^{address[31:ADDR_BITS], address[1:0]};
   assign mem_busy    = (state == WAIT);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      accept   = 1'b0;
      complete = 1'b0;
      case (state)
         IDLE: begin
            if (mem_req) begin
               accept   = 1'b1;
               cnt_nx   = CNT_LOAD;
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (cnt != '0) begin
               cnt_nx = cnt - CW'(1);
            end else begin
               complete = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         wr           <= 1'b0;
         wdata        <= '0;
         mem_done     <= 1'b0;
         mem_data_out <= '0;
         req_dropped  <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         mem_done <= complete;
         if (accept) begin
            idx   <= address[ADDR_BITS-1:2];
            wr    <= write_en;
            wdata <= mem_data_in;
         end
         if (complete && !wr) begin
            mem_data_out <= mem[idx];
         end
         if (state == WAIT && mem_req) begin
            req_dropped <= 1'b1;
         end
      end
   end

   // Array is never reset; complete is low while reset holds state in IDLE, so an aborted write is lost.
   always_ff @(posedge clk) begin
      if (complete && wr) begin
         mem[idx] <= wdata;
      end
   end
endmodule

// File: tb/tb_data_memory.sv
// Directed plus randomized checks of data_memory at LATENCY=4 (u_dut0) and LATENCY=1 (u_dut1)
// against an associative-array memory model.
module tb_data_memory;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst  [2];
   logic            req  [2];
   logic [31:0]     adr  [2];
   logic            wen  [2];
   logic [0:3][7:0] din  [2];
   logic [0:3][7:0] dout [2];
   logic [1:0]      busy, done, dropped;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   logic [31:0] model [int];

   always @(posedge clk) cyc <= cyc + 1;

   data_memory #(.SIZE(65536), .LATENCY(4), .ADDR_BITS(16)) u_dut0 (
      .clk(clk), .reset(rst[0]), .mem_req(req[0]), .address(adr[0]), .write_en(wen[0]),
      .mem_data_in(din[0]), .mem_data_out(dout[0]), .mem_busy(busy[0]), .mem_done(done[0]),
      .req_dropped(dropped[0]));

   data_memory #(.SIZE(65536), .LATENCY(1), .ADDR_BITS(16)) u_dut1 (
      .clk(clk), .reset(rst[1]), .mem_req(req[1]), .address(adr[1]), .write_en(wen[1]),
      .mem_data_in(din[1]), .mem_data_out(dout[1]), .mem_busy(busy[1]), .mem_done(done[1]),
      .req_dropped(dropped[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic int key(input int d, input logic [31:0] a);
      return d * 65536 + int'(a[15:2]);
   endfunction

   function automatic int lat_of(input int d);
      return (d == 0) ? 4 : 1;
   endfunction

   // Starts mid-cycle, ends on the negedge where done is seen.
   task automatic xact(input int d, input logic [31:0] a, input logic we, input logic [31:0] wd,
                       input logic [31:0] exp_rd, output int done_cyc);
      logic [31:0] prev;
      bit          seen;
      int          busy_n;
      prev     = dout[d];
      seen     = 0;
      busy_n   = 0;
      done_cyc = 0;
      req[d] = 1'b1; adr[d] = a; wen[d] = we; din[d] = wd;
      @(posedge clk);
      for (int k = 1; k <= 60 && !seen; k++) begin
         @(negedge clk);
         if (k == 1) begin
            req[d] = 1'b0; wen[d] = 1'($urandom); din[d] = $urandom; adr[d] = $urandom;
         end
         busy_n += int'(busy[d]);
         if (done[d]) begin
            seen     = 1;
            done_cyc = cyc;
            check("latency", 32'(k - 1), 32'(lat_of(d)));
            check("busy_cycles", 32'(busy_n), 32'(lat_of(d)));
            if (we) check("write_keeps_dout", dout[d], prev);
            else    check("read_data", dout[d], exp_rd);
         end else begin
            check("dout_hold", dout[d], prev);
         end
      end
      if (!seen) check("done_timeout", 32'(seen), 32'd1);
   endtask

   task automatic idle_check(input int d);
      @(negedge clk);
      check("done_one_cycle", 32'(done[d]), 32'd0);
      check("busy_after_done", 32'(busy[d]), 32'd0);
   endtask

   task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v);
      int c;
      xact(d, a, 1'b1, v, 32'h0, c);
      model[key(d, a)] = v;
      idle_check(d);
   endtask

   task automatic rd(input int d, input logic [31:0] a);
      int c;
      xact(d, a, 1'b0, $urandom, model[key(d, a)], c);
      idle_check(d);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit          seen;
      int          c1, c2, d;
      logic [31:0] a, b1, b2;

      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b0; req[i] = 1'b0; adr[i] = '0; wen[i] = 1'b0; din[i] = '0;
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         check("rst_busy", 32'(busy[i]), 32'd0);
         check("rst_done", 32'(done[i]), 32'd0);
         check("rst_dout", dout[i], 32'h0);
         check("rst_dropped", 32'(dropped[i]), 32'd0);
      end
      @(negedge clk);
      rst[0] = 1'b1; rst[1] = 1'b1;
      @(negedge clk);

      // Basic write then read
      wr(0, 32'h0000_0040, 32'hDEAD_BEEF);
      check("wr_no_dout", dout[0], 32'h0);
      rd(0, 32'h0000_0040);
      check("lane0", 32'(dout[0][0]), 32'hDE);
      check("lane3", 32'(dout[0][3]), 32'hEF);

      // Wrap and byte-offset aliasing
      wr(0, 32'h0001_0043, 32'h1234_5678);
      rd(0, 32'h0000_0040);

      // Overrun: a write arriving mid-read is dropped
      check("drop_init", 32'(dropped[0]), 32'd0);
      req[0] = 1'b1; adr[0] = 32'h40; wen[0] = 1'b0;
      @(posedge clk); @(negedge clk); req[0] = 1'b0;
      @(posedge clk); @(negedge clk);
      req[0] = 1'b1; wen[0] = 1'b1; din[0] = 32'hFFFF_FFFF;
      @(posedge clk); @(negedge clk); req[0] = 1'b0;
      check("drop_set", 32'(dropped[0]), 32'd1);
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (done[0]) seen = 1;
         else @(negedge clk);
      end
      check("drop_done_seen", 32'(seen), 32'd1);
      check("drop_rdata", dout[0], 32'h1234_5678);
      idle_check(0);
      rd(0, 32'h0000_0040);
      check("drop_sticky", 32'(dropped[0]), 32'd1);

      // Back-to-back reads issued on the done cycle
      b1 = $urandom; b2 = $urandom;
      wr(0, 32'h100, b1);
      wr(0, 32'h104, b2);
      xact(0, 32'h100, 1'b0, 32'h0, b1, c1);
      xact(0, 32'h104, 1'b0, 32'h0, b2, c2);
      check("b2b_gap", 32'(c2 - c1), 32'd5);
      idle_check(0);

      // Reset in the middle of a write
      wr(0, 32'h80, 32'h1122_3344);
      req[0] = 1'b1; adr[0] = 32'h80; wen[0] = 1'b1; din[0] = 32'hCAFE_F00D;
      @(posedge clk); @(negedge clk); req[0] = 1'b0; din[0] = $urandom;
      @(posedge clk); @(negedge clk);
      rst[0] = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy[0]), 32'd0);
      check("mid_rst_done", 32'(done[0]), 32'd0);
      check("mid_rst_dout", dout[0], 32'h0);
      check("mid_rst_dropped", 32'(dropped[0]), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("mid_rst_no_done", 32'(done[0]), 32'd0);
      end
      rst[0] = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_rst_no_done", 32'(done[0]), 32'd0);
      end
      rd(0, 32'h80);

      // Single-cycle latency instance
      wr(1, 32'h4, 32'hA5A5_A5A5);
      rd(1, 32'h4);

      // Randomized mix on both instances
      for (int i = 0; i < 40; i++) begin
         d = i % 2;
         a = {16'($urandom), 14'(14'h80 + 14'($urandom_range(0, 7))), 2'($urandom)};
         if (model.exists(key(d, a)) && $urandom_range(0, 1) == 1) rd(d, a);
         else wr(d, a, $urandom);
      end
      check("final_no_drop0", 32'(dropped[0]), 32'd0);
      check("final_no_drop1", 32'(dropped[1]), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
